sprite_animator: RTL and testbench

SPRITE_ANIMATOR -- requirements
Module: sprite_animator

---
 rtl/sprite_animator.sv | 164 ++++++++++++++++
 tb/tb_sprite_animator.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_animator.sv
// sprite_animator: frame sequencer (LOOP/PINGPONG/ONESHOT/STILL) plus registered
// sprite window detect and ROM address generation for a horizontal sprite strip.
module sprite_animator #(
    parameter int NUM_FRAMES  = 4,
    parameter int SPRITE_W    = 40,
    parameter int SPRITE_H    = 40,
    parameter int HOLD_TICKS  = 4,
    parameter int BASE_OFFSET = 42724,
    parameter int LEFT_OFFSET = 50620,
    parameter int ADDR_W      = 21
) (
    input  logic              frame_Clk,
    input  logic              Reset,
    input  logic              anim_tick,
    input  logic              moving,
    input  logic              playerDirection,
    input  logic [1:0]        mode,
    input  logic              trigger,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        PlayerX,
    input  logic [9:0]        PlayerY,
    output logic              playerOn,
    output logic [ADDR_W-1:0] spriteAddress,
    output logic [3:0]        frame_idx,
    output logic              anim_done,
    output logic [9:0]        PlayerWidth,
    output logic [9:0]        PlayerHeight
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0]  M_LOOP   = 2'd0;
    localparam logic [1:0]  M_PING   = 2'd1;
    localparam logic [1:0]  M_ONE    = 2'd2;
    localparam logic [1:0]  M_STILL  = 2'd3;
    localparam logic [3:0]  LAST     = 4'(NUM_FRAMES - 1);
    localparam logic [3:0]  HLAST    = 4'(HOLD_TICKS - 1);
    localparam logic [21:0] FRAME_SZ = 22'(SPRITE_W * SPRITE_H);

    state_t            state_q, state_d;
    logic [3:0]        frame_q, frame_d;
    logic [3:0]        hold_q, hold_d;
    logic              up_q, up_d;
    logic              dir_q, dir_d;
    logic              done_q, done_d;
    logic [1:0]        mode_q;
    logic              on_q;
    logic [ADDR_W-1:0] addr_q;

    logic              animated, last_frame, hold_wrap;
    logic              in_x, in_y, in_win;
    logic [9:0]        dx, dy;
    logic [21:0]       addr_full;

    assign animated   = (mode == M_LOOP) || (mode == M_PING);
    assign last_frame = frame_q == LAST;
    assign hold_wrap  = hold_q == HLAST;

    // 11-bit compares so a sprite near X/Y=1023 does not wrap the window end
    assign in_x   = ({1'b0, DrawX} >= {1'b0, PlayerX}) &&
                    ({1'b0, DrawX} < {1'b0, PlayerX} + 11'(SPRITE_W));
    assign in_y   = ({1'b0, DrawY} >= {1'b0, PlayerY}) &&
                    ({1'b0, DrawY} < {1'b0, PlayerY} + 11'(SPRITE_H));
    assign in_win = in_x && in_y;
    assign dx     = DrawX - PlayerX;
    assign dy     = DrawY - PlayerY;

    assign addr_full = 22'(BASE_OFFSET) + (dir_q ? 22'(LEFT_OFFSET) : 22'd0) +
                       {18'd0, frame_q} * FRAME_SZ +
                       {12'd0, dy} * 22'(SPRITE_W) + {12'd0, dx};

    always_ff @(posedge frame_Clk) begin
        mode_q <= mode;
        if (Reset) begin
            state_q <= IDLE;
            frame_q <= '0;
            hold_q  <= '0;
            up_q    <= 1'b1;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            on_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            hold_q  <= hold_d;
            up_q    <= up_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            on_q    <= in_win;
            if (in_win) addr_q <= ADDR_W'(addr_full);
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        hold_d  = hold_q;
        up_d    = up_q;
        done_d  = done_q;
        dir_d   = anim_tick ? playerDirection : dir_q;
        if (mode != mode_q) begin
            state_d = IDLE;
            frame_d = '0;
            hold_d  = '0;
            up_d    = 1'b1;
            done_d  = 1'b0;
        end else if (trigger && mode == M_ONE) begin
            state_d = RUN;
            frame_d = '0;
            hold_d  = '0;
            done_d  = 1'b0;
        end else if (anim_tick) begin
            case (state_q)
                IDLE: begin
                    frame_d = '0;
                    hold_d  = '0;
                    up_d    = 1'b1;
                    if ((animated && moving) || mode == M_ONE) state_d = RUN;
                end
                RUN: begin
                    if (mode == M_STILL || (animated && !moving)) begin
                        state_d = IDLE;
                        frame_d = '0;
                        hold_d  = '0;
                        up_d    = 1'b1;
                    end else if (!hold_wrap) begin
                        hold_d = hold_q + 4'd1;
                    end else begin
                        hold_d = '0;
                        if (mode == M_LOOP) begin
                            frame_d = last_frame ? 4'd0 : frame_q + 4'd1;
                        end else if (mode == M_PING) begin
                            if (LAST == 4'd0) begin
                                frame_d = '0;
                            end else if (up_q) begin
                                frame_d = last_frame ? frame_q - 4'd1 : frame_q + 4'd1;
                                up_d    = !last_frame;
                            end else begin
                                frame_d = (frame_q == 4'd0) ? 4'd1 : frame_q - 4'd1;
                                up_d    = frame_q == 4'd0;
                            end
                        end else begin
                            frame_d = last_frame ? frame_q : frame_q + 4'd1;
                            if (last_frame || frame_q + 4'd1 == LAST) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign playerOn      = on_q;
    assign spriteAddress = addr_q;
    assign frame_idx     = frame_q;
    assign anim_done     = done_q;
    assign PlayerWidth   = 10'(SPRITE_W);
    assign PlayerHeight  = 10'(SPRITE_H);
endmodule

// File: tb/tb_sprite_animator.sv
// tb_sprite_animator: directed and random stimulus against a tick-count
// reference model of the sprite animator.
module tb_sprite_animator;
    localparam int N = 4, W = 40, H = 40, HT = 4, BASE = 42724, LEFT = 50620;

    logic        frame_Clk = 1'b0;
    logic        Reset, anim_tick, moving, playerDirection, trigger;
    logic [1:0]  mode;
    logic [9:0]  DrawX, DrawY, PlayerX, PlayerY;
    logic        playerOn, anim_done;
    logic [20:0] spriteAddress;
    logic [3:0]  frame_idx;
    logic [9:0]  PlayerWidth, PlayerHeight;

    int checks = 0, failures = 0;

    // model: run is described by ticks-since-start, frame derived arithmetically
    int       m_t, m_addr, guard;
    bit       m_run, m_done, m_dir, m_on;
    logic [1:0] m_prev, m_rmode;

    sprite_animator dut (
        .frame_Clk(frame_Clk), .Reset(Reset), .anim_tick(anim_tick), .moving(moving),
        .playerDirection(playerDirection), .mode(mode), .trigger(trigger),
        .DrawX(DrawX), .DrawY(DrawY), .PlayerX(PlayerX), .PlayerY(PlayerY),
        .playerOn(playerOn), .spriteAddress(spriteAddress), .frame_idx(frame_idx),
        .anim_done(anim_done), .PlayerWidth(PlayerWidth), .PlayerHeight(PlayerHeight)
    );

    initial forever #5 frame_Clk = ~frame_Clk;

    function automatic int m_frame();
        int k, p;
        if (!m_run && !m_done) return 0;
        k = m_t / HT;
        if (m_rmode == 2'd0) return k % N;
        if (m_rmode == 2'd1) begin
            if (N == 1) return 0;
            p = k % (2 * N - 2);
            return (p < N) ? p : 2 * N - 2 - p;
        end
        return (k < N - 1) ? k : N - 1;
    endfunction

    function automatic void model_edge();
        int px, py, x, y;
        bit win;
        if (Reset) begin
            m_run = 0; m_done = 0; m_t = 0; m_dir = 0; m_on = 0; m_addr = 0;
            m_prev = mode;
            return;
        end
        px = int'(PlayerX); py = int'(PlayerY); x = int'(DrawX); y = int'(DrawY);
        win = (x >= px) && (x < px + W) && (y >= py) && (y < py + H);
        if (win) m_addr = (BASE + (m_dir ? LEFT : 0) + m_frame() * W * H + (y - py) * W + (x - px)) % (2 ** 21);
        m_on = win;
        if (anim_tick) m_dir = playerDirection;
        if (mode != m_prev) begin
            m_run = 0; m_done = 0; m_t = 0;
        end else if (trigger && mode == 2'd2) begin
            m_run = 1; m_done = 0; m_t = 0; m_rmode = mode;
        end else if (anim_tick && !m_done) begin
            if (!m_run) begin
                if ((mode < 2'd2 && moving) || mode == 2'd2) begin
                    m_run = 1; m_t = 0; m_rmode = mode;
                end
            end else if (mode == 2'd3 || (mode < 2'd2 && !moving)) begin
                m_run = 0; m_t = 0;
            end else begin
                m_t++;
                if (mode == 2'd2 && m_t / HT >= ((N > 1) ? N - 1 : 1)) begin
                    m_run = 0; m_done = 1;
                end
            end
        end
        m_prev = mode;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge frame_Clk);
        #1;
        chk("frame_idx", 32'(frame_idx), 32'(m_frame()));
        chk("anim_done", 32'(anim_done), 32'(m_done));
        chk("playerOn", 32'(playerOn), 32'(m_on));
        chk("spriteAddress", 32'(spriteAddress), 32'(m_addr));
    endtask

    task automatic run_to_frame(input int f);
        guard = 0;
        anim_tick = 1'b1;
        while (m_frame() != f && guard < 100) begin
            step();
            guard++;
        end
        anim_tick = 1'b0;
    endtask

    initial begin
        Reset = 1; anim_tick = 0; moving = 1; playerDirection = 0; trigger = 0; mode = 2'd0;
        PlayerX = 10'd100; PlayerY = 10'd200; DrawX = 10'd0; DrawY = 10'd0;
        step(); step();
        chk("reset_frame", 32'(frame_idx), 0);
        chk("reset_addr", 32'(spriteAddress), 0);
        chk("width", 32'(PlayerWidth), 40);
        chk("height", 32'(PlayerHeight), 40);
        Reset = 0;

        // LOOP: one tick enters RUN, four more reach frame 1
        anim_tick = 1;
        for (int i = 0; i < 5; i++) step();
        anim_tick = 0;
        DrawX = PlayerX + 10'd3; DrawY = PlayerY + 10'd2;
        step();
        chk("loop_frame1", 32'(frame_idx), 1);
        chk("loop_addr", 32'(spriteAddress), 44407);
        anim_tick = 1;
        for (int i = 0; i < 16; i++) step();
        chk("loop_wrap", 32'(frame_idx), 1);

        // moving dropped at frame 2: frame holds until the next tick
        run_to_frame(2);
        moving = 0;
        for (int i = 0; i < 3; i++) step();
        chk("drop_hold", 32'(frame_idx), 2);
        anim_tick = 1; step(); anim_tick = 0;
        chk("drop_idle", 32'(frame_idx), 0);
        moving = 1;

        // PINGPONG full bounce
        mode = 2'd1; step();
        anim_tick = 1;
        for (int i = 0; i < 29; i++) step();
        chk("pp_after_bounce", 32'(frame_idx), 1);
        anim_tick = 0;

        // ONESHOT
        mode = 2'd2; step();
        trigger = 1; step(); trigger = 0;
        anim_tick = 1;
        for (int i = 0; i < 12; i++) step();
        chk("one_frame", 32'(frame_idx), 3);
        chk("one_done", 32'(anim_done), 1);
        for (int i = 0; i < 8; i++) step();
        chk("one_stay", 32'(frame_idx), 3);
        trigger = 1; step(); trigger = 0; anim_tick = 0;
        chk("one_retrig_frame", 32'(frame_idx), 0);
        chk("one_retrig_done", 32'(anim_done), 0);

        // facing, using STILL so the frame stays 0
        mode = 2'd3; step();
        playerDirection = 0; anim_tick = 1; step(); anim_tick = 0;
        DrawX = PlayerX + 10'd5; DrawY = PlayerY + 10'd7;
        step();
        chk("face_right", 32'(spriteAddress), 43009);
        playerDirection = 1; step(); step();
        chk("face_no_tick", 32'(spriteAddress), 43009);
        anim_tick = 1; step(); anim_tick = 0; step();
        chk("face_left", 32'(spriteAddress), 93629);
        DrawX = PlayerX + 10'd40; step();
        chk("edge_x_off", 32'(playerOn), 0);
        chk("edge_x_hold", 32'(spriteAddress), 93629);
        DrawX = PlayerX + 10'd39; DrawY = PlayerY + 10'd39; step();
        chk("edge_in", 32'(playerOn), 1);
        PlayerX = 10'd1000; DrawX = 10'd1020; step();
        chk("edge_1023", 32'(playerOn), 1);
        DrawX = 10'd5; step();
        chk("edge_wrap_off", 32'(playerOn), 0);
        PlayerX = 10'd100; DrawX = 10'd110; DrawY = PlayerY + 10'd40; step();
        chk("edge_y_off", 32'(playerOn), 0);

        // reset mid-RUN at frame 2
        mode = 2'd0; playerDirection = 0; step();
        DrawY = PlayerY + 10'd1;
        run_to_frame(2);
        chk("pre_reset_frame", 32'(frame_idx), 2);
        Reset = 1; step(); Reset = 0;
        chk("rst_frame", 32'(frame_idx), 0);
        chk("rst_done", 32'(anim_done), 0);
        chk("rst_addr", 32'(spriteAddress), 0);
        chk("rst_on", 32'(playerOn), 0);

        // random phase
        for (int i = 0; i < 3000; i++) begin
            Reset = ($urandom_range(0, 400) == 0);
            anim_tick = ($urandom_range(0, 2) == 0);
            trigger = ($urandom_range(0, 30) == 0);
            playerDirection = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 80) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 40) == 0) moving = ~moving;
            if ($urandom_range(0, 100) == 0) begin
                PlayerX = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(980, 1023)) : 10'($urandom);
                PlayerY = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(980, 1023)) : 10'($urandom);
            end
            DrawX = PlayerX + 10'($urandom_range(0, 49)) - 10'd5;
            DrawY = PlayerY + 10'($urandom_range(0, 49)) - 10'd5;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
